// File: rtl/kgp_trace_pkg.sv
// kgp_trace_pkg: shared state encodings, trigger modes and trace entry layout for kgp_trace_buffer.
// Entry width depends on KGP_TRACE_TIMESTAMP_EN (timestamp stored as the entry MSBs when defined).
package kgp_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] TRIG_IMM  = 2'd0;
    localparam logic [1:0] TRIG_PC   = 2'd1;
    localparam logic [1:0] TRIG_LS   = 2'd2;
    localparam logic [1:0] TRIG_RSVD = 2'd3;

`ifdef KGP_TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Entry layout, LSB first: alu_out, instr, pc, ls_signal, flags[2:0], then optional timestamp.
    function automatic int entry_w(input int data_w, input int ts_w);
        return (TS_EN ? ts_w : 0) + 4 + 3 * data_w;
    endfunction

    function automatic int off_instr(input int data_w);
        return data_w;
    endfunction

    function automatic int off_pc(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int off_ls(input int data_w);
        return 3 * data_w;
    endfunction

    function automatic int off_flags(input int data_w);
        return 3 * data_w + 1;
    endfunction

    function automatic int off_ts(input int data_w);
        return 3 * data_w + 4;
    endfunction

endpackage

// File: rtl/kgp_trace_ram.sv
// kgp_trace_ram: simple dual-port trace storage, one write port and one registered read port (1-cycle latency).
module kgp_trace_ram #(
    parameter int DEPTH = 16,
    parameter int W = 100,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read data holds its value between reads and clears on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/kgp_trace_buffer.sv
// kgp_trace_buffer: triggered circular execution-trace capture with pop-based readout.
// Define KGP_TRACE_TIMESTAMP_EN to add a free-running timestamp to every stored entry.
module kgp_trace_buffer
    import kgp_trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH = 16,
    parameter int POST_DEPTH = 8,
    parameter int TS_W = 16,
    localparam int ENTRY_W = entry_w(DATA_W, TS_W),
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  pc,
    input  logic [DATA_W-1:0]  instr,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [2:0]         flags,
    input  logic               ls_signal,
    input  logic               arm,
    input  logic [1:0]         trig_mode,
    input  logic [DATA_W-1:0]  trig_pc,
    input  logic               rd_req,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_empty,
    output logic [CW-1:0]      count,
    output logic [1:0]         state,
    output logic               wrapped
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("kgp_trace_buffer: DEPTH must be a power of two >= 4");
    end
    if (POST_DEPTH < 0 || POST_DEPTH >= DEPTH) begin : g_bad_post
        $error("kgp_trace_buffer: POST_DEPTH must be in 0..DEPTH-1");
    end

    state_t        cur, nxt;
    logic [AW-1:0] wr_ptr, rd_ptr, wr_n, rd_n;
    logic [CW-1:0] cnt_n;
    logic [AW-1:0] post, post_n;
    logic          wrap_n, we, re, hit;
    logic [ENTRY_W-1:0] wdata;

`ifdef KGP_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= '0;
        else ts <= ts + 1'b1;
    end

    assign wdata = {ts, flags, ls_signal, pc, instr, alu_out};
`else
    assign wdata = {flags, ls_signal, pc, instr, alu_out};
`endif

    assign hit = (trig_mode == TRIG_IMM) ||
                 (trig_mode == TRIG_PC && pc == trig_pc) ||
                 (trig_mode == TRIG_LS && ls_signal);

    assign state    = cur;
    assign rd_empty = (count == '0);

    // Next-state logic: arm wins, then sample capture in ARMED/CAPTURE, then pops in DONE.
    always_comb begin
        nxt    = cur;
        wr_n   = wr_ptr;
        rd_n   = rd_ptr;
        cnt_n  = count;
        wrap_n = wrapped;
        post_n = post;
        we     = 1'b0;
        re     = 1'b0;
        if (arm) begin
            nxt    = ST_ARMED;
            wr_n   = '0;
            rd_n   = '0;
            cnt_n  = '0;
            wrap_n = 1'b0;
            post_n = '0;
        end else if ((cur == ST_ARMED || cur == ST_CAPTURE) && sample_valid) begin
            we   = 1'b1;
            wr_n = wr_ptr + 1'b1;
            if (count == CW'(DEPTH)) begin
                rd_n   = rd_ptr + 1'b1;
                wrap_n = 1'b1;
            end else begin
                cnt_n = count + 1'b1;
            end
            if (cur == ST_ARMED && hit) begin
                post_n = AW'(POST_DEPTH);
                nxt    = (POST_DEPTH == 0) ? ST_DONE : ST_CAPTURE;
            end else if (cur == ST_CAPTURE) begin
                post_n = post - 1'b1;
                nxt    = (post == AW'(1)) ? ST_DONE : ST_CAPTURE;
            end
        end else if (cur == ST_DONE && rd_req && count != '0) begin
            re    = 1'b1;
            rd_n  = rd_ptr + 1'b1;
            cnt_n = count - 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= ST_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
            post     <= '0;
            rd_valid <= 1'b0;
        end else begin
            cur      <= nxt;
            wr_ptr   <= wr_n;
            rd_ptr   <= rd_n;
            count    <= cnt_n;
            wrapped  <= wrap_n;
            post     <= post_n;
            rd_valid <= re;
        end
    end

    kgp_trace_ram #(
        .DEPTH(DEPTH),
        .W    (ENTRY_W)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .waddr(wr_ptr),
        .wdata(wdata),
        .re   (re),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );

endmodule
